// File: rtl/uart_resp_arb_if.sv
// Bundle between the three requesters / UART transmitter and the response arbiter.
// slave is the arbiter's side, master is the requester/UART side.
interface uart_resp_arb_if;
  logic [2:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] ack;
  logic [2:0] err;
  logic       trmt;
  logic [7:0] resp;
  logic       tx_done;
  logic       busy;

  modport slave  (input  req, data0, data1, data2, tx_done,
                  output ack, err, trmt, resp, busy);
  modport master (output req, data0, data1, data2, tx_done,
                  input  ack, err, trmt, resp, busy);
endinterface

// File: rtl/uart_resp_arb.sv
// Round-robin arbiter granting one of three requesters a byte slot on a UART
// transmitter, with a per-transfer timeout while waiting for tx_done.
module uart_resp_arb #(
   parameter int TIMEOUT = 8192
) (
   input logic           clk,
   input logic           rst_n,
   uart_resp_arb_if.slave bus
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [7:0]    resp_q, resp_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    ack_q, ack_d;
   logic [2:0]    err_q, err_d;
   logic [1:0]    pick;
   logic          tx_seen;

   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] c0, c1, c2;
      c0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
      c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      if (r[c0])      rr_pick = c0;
      else if (r[c1]) rr_pick = c1;
      else            rr_pick = c2;
   endfunction

   assign pick = rr_pick({1'b0, bus.req}, last_q);

   // Counter is zero only in the first WAIT cycle, which doubles as the guard
   // cycle where a stale tx_done from the previous byte is ignored.
   assign tx_seen = (cnt_q != '0) && bus.tx_done;

   always_comb begin
      state_d = state_q;
      resp_d  = resp_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ack_d   = 3'b000;
      err_d   = 3'b000;
      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               gnt_d   = pick;
               state_d = S_LAUNCH;
               case (pick)
                  2'd0:    resp_d = bus.data0;
                  2'd1:    resp_d = bus.data1;
                  default: resp_d = bus.data2;
               endcase
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // tx_done wins over a timeout landing in the same cycle
            if (tx_seen) begin
               ack_d   = 3'b001 << gnt_q;
               last_d  = gnt_q;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               err_d   = 3'b001 << gnt_q;
               last_d  = gnt_q;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         resp_q  <= 8'h00;
         gnt_q   <= 2'd0;
         last_q  <= 2'd2;
         cnt_q   <= '0;
         ack_q   <= 3'b000;
         err_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         resp_q  <= resp_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Decoded from state so reset clears them without waiting for an edge.
   assign bus.trmt = (state_q == S_LAUNCH);
   assign bus.busy = (state_q != S_IDLE);
   assign bus.ack  = ack_q;
   assign bus.err  = err_q;
   assign bus.resp = resp_q;

endmodule

// File: doc/uart_resp_arb.md
UART_RESP_ARB -- requirements
Module: uart_resp_arb

Interface
REQ-001 Parameter TIMEOUT, default 8192: maximum clk cycles spent in WAIT before a transfer is aborted.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  3  per-requester transmit request; bit i belongs to requester i.
REQ-005 data0, data1, data2  input  8 each  byte offered by requester 0/1/2.
REQ-006 ack  output  3  one-cycle pulse to requester i when its byte has been transmitted.
REQ-007 err  output  3  one-cycle pulse to requester i when its transfer timed out.
REQ-008 trmt  output  1  one-cycle transmit strobe to the UART transmitter.
REQ-009 resp  output  8  byte presented to the UART transmitter.
REQ-010 tx_done  input  1  UART transmit-complete flag, held high by the UART until the next trmt.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, LAUNCH and WAIT.
REQ-013 IDLE: if req is non-zero, grant one requester, capture its data byte into resp, store the grant index, and go to LAUNCH; otherwise remain in IDLE.
REQ-014 Arbitration SHALL be round-robin: search starts at index (last+1) mod 3, where last is the most recently granted index, and wraps 2->0.
REQ-015 LAUNCH: trmt is asserted for exactly this one cycle, the timeout counter is cleared, and the FSM goes to WAIT.
REQ-016 WAIT, first cycle: tx_done is ignored, as a guard cycle while the UART clears its flag.
REQ-017 WAIT, later cycles, tx_done high: pulse ack[grant] for one cycle, update last to grant, and go to IDLE.
REQ-018 WAIT: the timeout counter increments every cycle; when it reaches TIMEOUT-1 without tx_done, pulse err[grant], update last, and go to IDLE.
REQ-019 If tx_done and timeout occur in the same cycle, the outcome SHALL be ack; err SHALL not pulse.
REQ-020 The timeout counter SHALL be wide enough to hold TIMEOUT-1 and SHALL not wrap.
REQ-021 Latency: req first seen high in IDLE at edge n -> trmt high in cycle n+1.
REQ-022 At most one trmt SHALL be issued per grant; no new grant is made while busy.
REQ-023 resp and the grant index SHALL be held stable from capture until return to IDLE.
REQ-024 A requester SHALL hold req and its data stable until ack or err; the arbiter SHALL nonetheless complete any started transfer if req drops mid-transfer.
REQ-025 A requester holding req after ack SHALL be re-eligible in the next IDLE cycle, subject to round-robin order.
REQ-026 ack, err and trmt SHALL be one-hot-or-zero in every cycle.
REQ-027 Minimum spacing between consecutive trmt pulses is 4 cycles.

Reset
REQ-028 Asynchronous reset SHALL drive: state to IDLE, resp to 0x00, trmt/ack/err/busy to 0, the counter to 0, and last to 2 (so requester 0 is served first after reset).
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err pulse; outputs reach reset values immediately, without waiting for a clock edge.

Verification
REQ-030 Single request: req=001, data0=0xA5, tx_done pulled high 100 cycles after trmt -> trmt one cycle with resp=0xA5, then ack=001 for one cycle, busy falls.
REQ-031 Contention: req=111 held throughout with distinct data bytes -> service order 0,1,2,0,1,2 and ack order matches.
REQ-032 Timeout: TIMEOUT=16, req=010, tx_done held low -> err=010 exactly 16 cycles after WAIT entry, no ack.
REQ-033 Simultaneous events: tx_done rises on the same cycle the counter reaches TIMEOUT-1 -> ack pulses, err stays 0.
REQ-034 Stale flag: tx_done held high before and through LAUNCH, then dropped by the UART on trmt -> no ack during the guard cycle; ack only after tx_done rises again.
REQ-035 Reset mid-WAIT: drop rst_n -> busy=0 and trmt=0 at once; after release, req=011 -> requester 0 is granted first.
